regfile_mp: RTL and testbench

Parametrised two-write, two-read register file with a per-register busy scoreboard, succeeding the fixed 32x32 single-write register file in the CPU datapath. It serves the decode stage: two operand reads per cycle, one write from the ALU/writeback path and one from the memory/load path, plus reservation of a destination register when a multi-cycle operation issues. Register 0 always reads zero and is never busy.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 53 +++++
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the default geometry, the register-address type and the index
// of the hardwired zero register.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_AW-1:0] reg_addr_t;

  // Register 0 is never stored: it reads zero and is never busy.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file.
// One bit per architectural register except r0. A reserve sets a bit,
// either write port clears the bit for its address, and a reserve that
// lands on the same address as a write in the same cycle wins, so a new
// producer can issue in the very cycle its predecessor retires.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_a_en_i,
  input  logic [AW-1:0] clr_a_addr_i,
  input  logic          clr_b_en_i,
  input  logic [AW-1:0] clr_b_addr_i,
  input  logic [AW-1:0] lookup1_addr_i,
  input  logic [AW-1:0] lookup2_addr_i,
  output logic          busy1_o,
  output logic          busy2_o
);

  logic [DEPTH-1:1] busy_q;
  logic [DEPTH-1:1] busy_d;
  logic [DEPTH-1:0] busy_vec;

  // Next busy state: clears from both write ports first, reserve last.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (clr_a_en_i && (clr_a_addr_i == AW'(i))) busy_d[i] = 1'b0;
      if (clr_b_en_i && (clr_b_addr_i == AW'(i))) busy_d[i] = 1'b0;
      if (set_en_i   && (set_addr_i   == AW'(i))) busy_d[i] = 1'b1;
    end
  end

  // Busy register; reset overrides any set or clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Full-width view with r0 hardwired idle, so lookups need no guard.
  always_comb begin
    busy_vec = {busy_q, 1'b0};
    busy1_o  = busy_vec[lookup1_addr_i];
    busy2_o  = busy_vec[lookup2_addr_i];
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, two-read register file with per-register busy scoreboard.
// Port A is the ALU/writeback path, port B the load-return path; when
// both hit the same register in one cycle, port B's data is kept.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle
// write-to-read forwarding on both read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [AW-1:0]    Ard1,
  input  logic [AW-1:0]    Ard2,
  output logic [WIDTH-1:0] Dout1,
  output logic [WIDTH-1:0] Dout2,
  output logic             Busy1,
  output logic             Busy2,
  input  logic [AW-1:0]    Awr,
  input  logic [WIDTH-1:0] Din,
  input  logic             WrEn,
  input  logic [AW-1:0]    Awr2,
  input  logic [WIDTH-1:0] Din2,
  input  logic             WrEn2,
  input  logic             RsvEn,
  input  logic [AW-1:0]    Arsv
);

  logic [WIDTH-1:0] mem_q   [1:DEPTH-1];
  logic [WIDTH-1:0] mem_d   [1:DEPTH-1];
  logic [WIDTH-1:0] rd_view [DEPTH];
  logic             sb_busy1;
  logic             sb_busy2;

  // Next data state: port A first, port B applied after so it wins.
  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (WrEn  && (Awr  == AW'(i))) mem_d[i] = Din;
      if (WrEn2 && (Awr2 == AW'(i))) mem_d[i] = Din2;
    end
  end

  // Data registers; reset discards any write in the same cycle.
  always_ff @(posedge Clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (Rst) mem_q[i] <= '0;
      else     mem_q[i] <= mem_d[i];
    end
  end

  // Read view with r0 hardwired to zero.
  always_comb begin
    rd_view[0] = '0;
    for (int i = 1; i < DEPTH; i++) rd_view[i] = mem_q[i];
  end

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i          (Clk),
    .rst_i          (Rst),
    .set_en_i       (RsvEn),
    .set_addr_i     (Arsv),
    .clr_a_en_i     (WrEn),
    .clr_a_addr_i   (Awr),
    .clr_b_en_i     (WrEn2),
    .clr_b_addr_i   (Awr2),
    .lookup1_addr_i (Ard1),
    .lookup2_addr_i (Ard2),
    .busy1_o        (sb_busy1),
    .busy2_o        (sb_busy2)
  );

`ifdef REGFILE_BYPASS_EN
  // Forwarding reads: an in-flight write to the read address supplies the
  // data and retires the reservation, unless a new reserve hits it too.
  always_comb begin
    Dout1 = rd_view[Ard1];
    Busy1 = sb_busy1;
    Dout2 = rd_view[Ard2];
    Busy2 = sb_busy2;
    if (Ard1 != AW'(REG_ZERO)) begin
      if (WrEn && (Awr == Ard1)) begin
        Dout1 = Din;
        Busy1 = RsvEn && (Arsv == Ard1);
      end
      if (WrEn2 && (Awr2 == Ard1)) begin
        Dout1 = Din2;
        Busy1 = RsvEn && (Arsv == Ard1);
      end
    end
    if (Ard2 != AW'(REG_ZERO)) begin
      if (WrEn && (Awr == Ard2)) begin
        Dout2 = Din;
        Busy2 = RsvEn && (Arsv == Ard2);
      end
      if (WrEn2 && (Awr2 == Ard2)) begin
        Dout2 = Din2;
        Busy2 = RsvEn && (Arsv == Ard2);
      end
    end
  end
`else
  // Plain reads of the stored state.
  always_comb begin
    Dout1 = rd_view[Ard1];
    Busy1 = sb_busy1;
    Dout2 = rd_view[Ard2];
    Busy2 = sb_busy2;
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp.
// Expected {busy, data} pairs go into exp_q when stimulus is driven and
// are popped and compared when the read ports are sampled at negedge.
module tb_regfile_mp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int W     = WIDTH + 1;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [AW-1:0]    Ard1, Ard2, Awr, Awr2, Arsv;
  logic [WIDTH-1:0] Dout1, Dout2, Din, Din2;
  logic             Busy1, Busy2, WrEn, WrEn2, RsvEn;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, exp_v;

  logic [WIDTH-1:0] m_data [DEPTH];
  logic             m_busy [DEPTH];

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .Ard1(Ard1), .Ard2(Ard2),
    .Dout1(Dout1), .Dout2(Dout2),
    .Busy1(Busy1), .Busy2(Busy2),
    .Awr(Awr), .Din(Din), .WrEn(WrEn),
    .Awr2(Awr2), .Din2(Din2), .WrEn2(WrEn2),
    .RsvEn(RsvEn), .Arsv(Arsv)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Rst = 1'b0; WrEn = 1'b0; WrEn2 = 1'b0; RsvEn = 1'b0;
    Awr = '0; Awr2 = '0; Arsv = '0; Din = '0; Din2 = '0;
    Ard1 = '0; Ard2 = '0;
  endtask

  task automatic do_reset();
    idle();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    WrEn = 1'b1; Awr = 5'd5; Din = 32'hDEADBEEF;
    tick();
    idle(); Ard1 = 5'd5;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL pre_reset_r5 got=%h need=%h", got, exp_v); end
    Rst = 1'b1;
    tick();
    idle(); Ard1 = 5'd5; Ard2 = 5'd5;
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h0});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL reset_r5_p1 got=%h need=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {Busy2, Dout2}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL reset_r5_p2 got=%h need=%h", got, exp_v); end
    // Reset mid-operation: commit data and reserve, then reset with a pending write.
    tick();
    WrEn = 1'b1; Awr = 5'd3; Din = 32'h77; RsvEn = 1'b1; Arsv = 5'd3;
    tick();
    Rst = 1'b1; Din = 32'h88;
    tick();
    idle(); Ard1 = 5'd3;
    exp_q.push_back({1'b0, 32'h0});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL reset_midop_r3 got=%h need=%h", got, exp_v); end
  endtask

  task automatic test_dual_write();
    tick();
    idle();
    WrEn = 1'b1; Awr = 5'd3; Din = 32'h11;
    WrEn2 = 1'b1; Awr2 = 5'd7; Din2 = 32'h22;
    tick();
    idle(); Ard1 = 5'd3; Ard2 = 5'd7;
    exp_q.push_back({1'b0, 32'h11});
    exp_q.push_back({1'b0, 32'h22});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL dual_write_r3 got=%h need=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {Busy2, Dout2}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL dual_write_r7 got=%h need=%h", got, exp_v); end
  endtask

  task automatic test_collision();
    tick();
    idle();
    WrEn = 1'b1; Awr = 5'd9; Din = 32'hAA;
    WrEn2 = 1'b1; Awr2 = 5'd9; Din2 = 32'hBB;
    tick();
    idle(); Ard1 = 5'd9; Ard2 = 5'd9;
    exp_q.push_back({1'b0, 32'hBB});
    exp_q.push_back({1'b0, 32'hBB});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL collision_p1 got=%h need=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {Busy2, Dout2}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL collision_p2 got=%h need=%h", got, exp_v); end
  endtask

  task automatic test_scoreboard();
    tick();
    idle(); RsvEn = 1'b1; Arsv = 5'd4;
    tick();
    idle(); Ard1 = 5'd4; Ard2 = 5'd4;
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL reserve_r4_p1 got=%h need=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {Busy2, Dout2}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL reserve_r4_p2 got=%h need=%h", got, exp_v); end
    tick();
    idle(); WrEn2 = 1'b1; Awr2 = 5'd4; Din2 = 32'h55;
    tick();
    idle(); Ard1 = 5'd4;
    exp_q.push_back({1'b0, 32'h55});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL release_r4 got=%h need=%h", got, exp_v); end
    tick();
    idle(); WrEn = 1'b1; Awr = 5'd4; Din = 32'h66; RsvEn = 1'b1; Arsv = 5'd4;
    tick();
    idle(); Ard1 = 5'd4;
    exp_q.push_back({1'b1, 32'h66});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL rsv_wins_r4 got=%h need=%h", got, exp_v); end
  endtask

  task automatic test_r0();
    tick();
    idle();
    WrEn = 1'b1; Awr = 5'd0; Din = 32'hFFFFFFFF;
    WrEn2 = 1'b1; Awr2 = 5'd0; Din2 = 32'hFFFFFFFF;
    RsvEn = 1'b1; Arsv = 5'd0;
    exp_q.push_back({1'b0, 32'h0});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL r0_same_cycle got=%h need=%h", got, exp_v); end
    tick();
    idle(); Ard1 = 5'd0; Ard2 = 5'd0;
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h0});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL r0_p1 got=%h need=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {Busy2, Dout2}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL r0_p2 got=%h need=%h", got, exp_v); end
  endtask

  task automatic test_bypass();
    tick();
    idle(); WrEn = 1'b1; Awr = 5'd6; Din = 32'h1; RsvEn = 1'b1; Arsv = 5'd6;
    tick();
    idle(); WrEn = 1'b1; Awr = 5'd6; Din = 32'h2; Ard1 = 5'd6; Ard2 = 5'd6;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back({1'b0, 32'h2});
    exp_q.push_back({1'b0, 32'h2});
`else
    exp_q.push_back({1'b1, 32'h1});
    exp_q.push_back({1'b1, 32'h1});
`endif
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL bypass_cycle_p1 got=%h need=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {Busy2, Dout2}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL bypass_cycle_p2 got=%h need=%h", got, exp_v); end
    tick();
    idle(); Ard1 = 5'd6;
    exp_q.push_back({1'b0, 32'h2});
    @(negedge Clk);
    exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
    if (got !== exp_v) begin bad++; $display("FAIL bypass_after got=%h need=%h", got, exp_v); end
  endtask

  task automatic test_random();
    int a;
    tick();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
    for (int n = 0; n < 80; n++) begin
      idle();
      WrEn  = 1'($urandom_range(0, 1));
      Awr   = AW'($urandom_range(0, 7));
      Din   = $urandom;
      WrEn2 = 1'($urandom_range(0, 1));
      Awr2  = ($urandom_range(0, 2) == 0) ? Awr : AW'($urandom_range(0, 7));
      Din2  = $urandom;
      RsvEn = 1'($urandom_range(0, 1));
      Arsv  = ($urandom_range(0, 2) == 0) ? Awr : AW'($urandom_range(0, 7));
      if (WrEn && Awr != 0)   begin m_data[Awr]  = Din;  m_busy[Awr]  = 1'b0; end
      if (WrEn2 && Awr2 != 0) begin m_data[Awr2] = Din2; m_busy[Awr2] = 1'b0; end
      if (RsvEn && Arsv != 0) m_busy[Arsv] = 1'b1;
      tick();
      idle();
      Ard1 = AW'($urandom_range(0, 7));
      Ard2 = AW'($urandom_range(0, 7));
      a = int'(Ard1);
      exp_q.push_back((a == 0) ? {1'b0, 32'h0} : {m_busy[a], m_data[a]});
      a = int'(Ard2);
      exp_q.push_back((a == 0) ? {1'b0, 32'h0} : {m_busy[a], m_data[a]});
      @(negedge Clk);
      exp_v = exp_q.pop_front(); got = {Busy1, Dout1}; total++;
      if (got !== exp_v) begin bad++; $display("FAIL random_p1 n=%0d a=%0d got=%h need=%h", n, Ard1, got, exp_v); end
      exp_v = exp_q.pop_front(); got = {Busy2, Dout2}; total++;
      if (got !== exp_v) begin bad++; $display("FAIL random_p2 n=%0d a=%0d got=%h need=%h", n, Ard2, got, exp_v); end
      tick();
    end
  endtask

  // Sequence and final report
  initial begin
    idle();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    test_reset();
    test_dual_write();
    test_collision();
    test_scoreboard();
    test_r0();
    test_bypass();
    test_random();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d need=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
